// File: rtl/ct_l2c_spsram_128x144_ctrl.sv
// Request-side controller for the 128x144 single-port L2C SRAM macro: zero-init after
// reset, valid/ready request conversion to active-low macro pins, 3-entry response FIFO.
module ct_l2c_spsram_128x144_ctrl #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 144
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   output logic                  init_done,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
   localparam int unsigned FIFO_DEPTH = 3;
   localparam int unsigned PTR_W      = 2;
   localparam int unsigned OCC_W      = 3;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];

   logic                  in_run;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [OCC_W-1:0]      occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake and credit: occupancy counts queued plus in-flight reads (registered only)
   always_comb begin
      occ       = OCC_W'(cnt_q) + OCC_W'(rd_pend_q);
      in_run    = cpurst_b & (state_q == ST_RUN);
      init_done = in_run;
      req_rdy   = in_run & (req_wr | (occ < OCC_W'(FIFO_DEPTH)));
      accept    = req_vld & req_rdy;
      rsp_vld   = cpurst_b & (cnt_q != '0);
      rsp_rdata = rsp_vld ? fifo_q[rd_ptr_q] : '0;
      push      = rd_pend_q;
      pop       = rsp_vld & rsp_rdy;
   end

   // Macro pins: init sweep writes zeros, otherwise follow the accepted request
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = '0;
      sram_d    = '0;
      if (cpurst_b) begin
         if (state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_addr_q;
         end else if (accept) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
               sram_gwen = 1'b0;
               sram_wen  = ~req_wmask;
               sram_d    = req_wdata;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      if (state_q == ST_INIT) begin
         if (init_addr_q == LAST_ADDR) begin
            state_d = ST_RUN;
         end else begin
            init_addr_d = init_addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   // Response FIFO: Q is captured the cycle after a read access
   always_comb begin
      rd_pend_d = accept & ~req_wr;
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (push) begin
         fifo_d[wr_ptr_q] = sram_q;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + PTR_W'(1);
         2'b01:   cnt_d = cnt_q - PTR_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         rd_pend_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         rd_pend_q   <= rd_pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_ct_l2c_spsram_128x144_ctrl.sv
// Randomised self-checking bench for ct_l2c_spsram_128x144_ctrl with a behavioural
// 128x144 macro and a transaction-level reference model.
module tb_ct_l2c_spsram_128x144_ctrl;

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 144;

   logic          clk;
   logic          cpurst_b;
   logic          init_done;
   logic          req_vld, req_rdy, req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata, req_wmask;
   logic          rsp_vld, rsp_rdy;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] sram_a;
   logic          sram_cen, sram_gwen;
   logic [DW-1:0] sram_wen, sram_d, sram_q;

   ct_l2c_spsram_128x144_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .forever_cpuclk(clk),
      .cpurst_b      (cpurst_b),
      .init_done     (init_done),
      .req_vld       (req_vld),
      .req_rdy       (req_rdy),
      .req_wr        (req_wr),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wmask     (req_wmask),
      .rsp_vld       (rsp_vld),
      .rsp_rdy       (rsp_rdy),
      .rsp_rdata     (rsp_rdata),
      .sram_a        (sram_a),
      .sram_cen      (sram_cen),
      .sram_gwen     (sram_gwen),
      .sram_wen      (sram_wen),
      .sram_d        (sram_d),
      .sram_q        (sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural macro: 1-cycle Q, active-low per-bit WEN, contents start as garbage
   logic [DW-1:0] macro_mem [128];
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= macro_mem[sram_a];
      end
   end

   typedef struct {
      logic [DW-1:0] data;
      int            acc;
   } rsp_t;

   logic [DW-1:0] ref_mem [128];
   rsp_t          exp_q [$];
   int            n_chk, n_err;
   int            cyc;
   logic          last_fire;
   logic [DW-1:0] last_pop;
   int            n_pop, n_rd_acc;
   int            vld_run, vld_max;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rand_dw();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Transaction-level checks at the falling edge, then advance one cycle
   task automatic run_cycle();
      logic exp_vld;
      @(negedge clk);
      exp_vld = (exp_q.size() > 0) && (exp_q[0].acc + 2 <= cyc);
      chk("init_done", DW'(init_done), DW'(1));
      chk("rsp_vld", DW'(rsp_vld), DW'(exp_vld));
      chk("rsp_rdata", rsp_rdata, exp_vld ? exp_q[0].data : '0);
      chk("req_rdy", DW'(req_rdy), DW'(req_wr || (exp_q.size() < 3)));
      vld_run = rsp_vld ? vld_run + 1 : 0;
      if (vld_run > vld_max) vld_max = vld_run;
      last_fire = req_vld && req_rdy;
      if (rsp_vld && rsp_rdy && exp_vld) begin
         last_pop = exp_q[0].data;
         void'(exp_q.pop_front());
         n_pop++;
      end
      if (last_fire) begin
         if (req_wr) begin
            ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
         end else begin
            exp_q.push_back('{data: ref_mem[req_addr], acc: cyc});
            n_rd_acc++;
         end
      end
      tick();
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] mask);
      int n;
      req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_wmask = mask;
      n = 0;
      do begin
         run_cycle();
         n++;
      end while (!last_fire && n < 40);
      if (!last_fire) chk("issue_timeout", DW'(0), DW'(1));
      req_vld = 1'b0;
   endtask

   task automatic drain();
      int n;
      req_vld = 1'b0;
      rsp_rdy = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 30) begin
         run_cycle();
         n++;
      end
      chk("drain_empty", DW'(exp_q.size()), DW'(0));
   endtask

   task automatic expect_init();
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 7'd9; req_wdata = '1; req_wmask = '1;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         chk("init_cen", DW'(sram_cen), DW'(0));
         chk("init_gwen", DW'(sram_gwen), DW'(0));
         chk("init_wen", sram_wen, '0);
         chk("init_d", sram_d, '0);
         chk("init_a", DW'(sram_a), DW'(i));
         chk("init_rdy", DW'(req_rdy), DW'(0));
         chk("init_done_lo", DW'(init_done), DW'(0));
         tick();
      end
      req_vld = 1'b0;
   endtask

   task automatic reset_pins_check();
      @(negedge clk);
      chk("rst_cen", DW'(sram_cen), DW'(1));
      chk("rst_gwen", DW'(sram_gwen), DW'(1));
      chk("rst_wen", sram_wen, '1);
      chk("rst_a", DW'(sram_a), DW'(0));
      chk("rst_d", sram_d, '0);
      chk("rst_rdy", DW'(req_rdy), DW'(0));
      chk("rst_rsp_vld", DW'(rsp_vld), DW'(0));
      chk("rst_init_done", DW'(init_done), DW'(0));
      tick();
   endtask

   initial begin
      int start, pops0;
      n_chk = 0; n_err = 0; cyc = 0; n_pop = 0; n_rd_acc = 0;
      vld_run = 0; vld_max = 0; last_fire = 1'b0; last_pop = '0;
      sram_q = rand_dw();
      for (int i = 0; i < 128; i++) begin
         macro_mem[i] = rand_dw();
         ref_mem[i]   = '0;
      end
      cpurst_b = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;

      reset_pins_check();
      reset_pins_check();
      cpurst_b = 1'b1;
      expect_init();

      // Full-mask write then read back
      issue(1'b1, 7'd5, {18{8'hA5}}, '1);
      issue(1'b0, 7'd5, '0, '0);
      drain();
      chk("t2_data", last_pop, {18{8'hA5}});

      // Partial mask keeps the upper half
      issue(1'b1, 7'd3, '1, '1);
      issue(1'b1, 7'd3, '0, {{72{1'b0}}, {72{1'b1}}});
      issue(1'b0, 7'd3, '0, '0);
      drain();
      chk("t3_data", last_pop, {{72{1'b1}}, {72{1'b0}}});

      // Credit limit: three reads accepted, fourth stalls until the consumer drains
      for (int i = 0; i < 5; i++) issue(1'b1, AW'(i), rand_dw(), '1);
      drain();
      pops0 = n_pop;
      rsp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0, '0);
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'd3;
      start = n_rd_acc;
      for (int i = 0; i < 6; i++) run_cycle();
      chk("t4_stall", DW'(n_rd_acc - start), DW'(0));
      chk("t4_queued", DW'(exp_q.size()), DW'(3));
      rsp_rdy = 1'b1;
      issue(1'b0, 7'd3, '0, '0);
      issue(1'b0, 7'd4, '0, '0);
      drain();
      chk("t4_pops", DW'(n_pop - pops0), DW'(5));

      // Streaming reads at one per cycle
      for (int i = 10; i < 18; i++) issue(1'b1, AW'(i), rand_dw(), '1);
      drain();
      vld_max = 0;
      start = cyc;
      for (int i = 10; i < 18; i++) issue(1'b0, AW'(i), '0, '0);
      chk("t5_rate", DW'(cyc - start), DW'(8));
      drain();
      chk("t5_vld_run", DW'(vld_max), DW'(8));

      // Reset with two responses queued and one in flight
      rsp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0, '0);
      chk("t6_queued", DW'(exp_q.size()), DW'(3));
      cpurst_b = 1'b0; req_vld = 1'b1; req_wr = 1'b0;
      reset_pins_check();
      reset_pins_check();
      exp_q.delete();
      for (int i = 0; i < 128; i++) ref_mem[i] = '0;
      cpurst_b = 1'b1;
      expect_init();
      rsp_rdy = 1'b1;

      // Random traffic on a small address window to exercise read-after-write
      req_vld = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (!req_vld || last_fire) begin
            req_vld   = ($urandom_range(0, 9) < 7);
            req_wr    = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 11));
            req_wdata = rand_dw();
            req_wmask = ($urandom_range(0, 3) == 0) ? '1 : rand_dw();
         end
         rsp_rdy = ($urandom_range(0, 3) != 0);
         run_cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
